// File: rtl/spi_reg_bridge.sv
// SPI mode-0 peripheral turning each 8+DATA_W bit frame into one register-bus access.
// Inputs sclk/ncs/mosi are already synchronized to clk; all logic is gated by ena.
module spi_reg_bridge #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              ena,
   input  logic              sclk,
   input  logic              ncs,
   input  logic              mosi,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              miso,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_we,
   output logic              frame_err
);

   localparam int CNT_W = (DATA_W > 8) ? $clog2(DATA_W) : 3;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CMD  = 3'd1,
      LOAD = 3'd2,
      DATA = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t            state_r, state_s;
   logic [CNT_W-1:0]  bit_cnt_r, bit_cnt_s;
   logic [7:0]        cmd_sr_r, cmd_sr_s;
   logic [DATA_W-1:0] tx_sr_r, tx_sr_s;
   logic [DATA_W-1:0] rx_sr_r, rx_sr_s;
   logic              sclk_prev_r;
   logic              rw_r, rw_s;
   logic              wr_pend_r, wr_pend_s;
   logic              miso_r, miso_s;
   logic [ADDR_W-1:0] reg_addr_r, reg_addr_s;
   logic [DATA_W-1:0] reg_wdata_r, reg_wdata_s;
   logic              reg_we_r, reg_we_s;
   logic              frame_err_r, frame_err_s;
   logic              rise_s, fall_s, abort_s;

   assign rise_s  = sclk & ~sclk_prev_r;
   assign fall_s  = ~sclk & sclk_prev_r;
   assign abort_s = ncs & ((state_r == CMD) | (state_r == LOAD) | (state_r == DATA));

   // State register; holds while ena is low.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_r <= IDLE;
      end else if (ena) begin
         state_r <= state_s;
      end
   end

   // Next-state and datapath decode; an ncs abort overrides any same-cycle sclk edge.
   always_comb begin
      state_s     = state_r;
      bit_cnt_s   = bit_cnt_r;
      cmd_sr_s    = cmd_sr_r;
      tx_sr_s     = tx_sr_r;
      rx_sr_s     = rx_sr_r;
      rw_s        = rw_r;
      wr_pend_s   = wr_pend_r;
      miso_s      = miso_r;
      reg_addr_s  = reg_addr_r;
      reg_wdata_s = reg_wdata_r;
      reg_we_s    = 1'b0;
      frame_err_s = 1'b0;
      if (abort_s) begin
         state_s     = IDLE;
         frame_err_s = 1'b1;
         miso_s      = 1'b0;
         wr_pend_s   = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               miso_s    = 1'b0;
               wr_pend_s = 1'b0;
               if (!ncs) begin
                  state_s   = CMD;
                  bit_cnt_s = '0;
               end else begin
                  state_s   = IDLE;
               end
            end
            CMD: begin
               miso_s = 1'b0;
               if (rise_s) begin
                  cmd_sr_s = {cmd_sr_r[6:0], mosi};
                  if (bit_cnt_r == CNT_W'(7)) begin
                     reg_addr_s = cmd_sr_s[ADDR_W-1:0];
                     rw_s       = cmd_sr_s[7];
                     bit_cnt_s  = '0;
                     state_s    = LOAD;
                  end else begin
                     bit_cnt_s  = bit_cnt_r + CNT_W'(1);
                  end
               end else begin
                  cmd_sr_s = cmd_sr_r;
               end
            end
            LOAD: begin
               tx_sr_s = rw_r ? '0 : reg_rdata;
               state_s = DATA;
            end
            DATA: begin
               if (fall_s) begin
                  miso_s  = tx_sr_r[DATA_W-1];
                  tx_sr_s = {tx_sr_r[DATA_W-2:0], 1'b0};
               end else if (rise_s) begin
                  rx_sr_s = {rx_sr_r[DATA_W-2:0], mosi};
                  if (bit_cnt_r == CNT_W'(DATA_W-1)) begin
                     state_s   = DONE;
                     wr_pend_s = rw_r;
                  end else begin
                     bit_cnt_s = bit_cnt_r + CNT_W'(1);
                  end
               end else begin
                  tx_sr_s = tx_sr_r;
               end
            end
            DONE: begin
               if (wr_pend_r) begin
                  reg_we_s    = 1'b1;
                  reg_wdata_s = rx_sr_r;
                  wr_pend_s   = 1'b0;
               end else begin
                  reg_we_s    = 1'b0;
               end
               if (ncs) begin
                  state_s = IDLE;
                  miso_s  = 1'b0;
               end else begin
                  state_s = DONE;
               end
            end
            default: begin
               state_s = IDLE;
               miso_s  = 1'b0;
            end
         endcase
      end
   end

   // Datapath and output registers; pulses stretch across ena-low cycles.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         bit_cnt_r   <= '0;
         cmd_sr_r    <= 8'h00;
         tx_sr_r     <= '0;
         rx_sr_r     <= '0;
         sclk_prev_r <= 1'b0;
         rw_r        <= 1'b0;
         wr_pend_r   <= 1'b0;
         miso_r      <= 1'b0;
         reg_addr_r  <= '0;
         reg_wdata_r <= '0;
         reg_we_r    <= 1'b0;
         frame_err_r <= 1'b0;
      end else if (ena) begin
         bit_cnt_r   <= bit_cnt_s;
         cmd_sr_r    <= cmd_sr_s;
         tx_sr_r     <= tx_sr_s;
         rx_sr_r     <= rx_sr_s;
         sclk_prev_r <= sclk;
         rw_r        <= rw_s;
         wr_pend_r   <= wr_pend_s;
         miso_r      <= miso_s;
         reg_addr_r  <= reg_addr_s;
         reg_wdata_r <= reg_wdata_s;
         reg_we_r    <= reg_we_s;
         frame_err_r <= frame_err_s;
      end
   end

   assign miso      = miso_r;
   assign reg_addr  = reg_addr_r;
   assign reg_wdata = reg_wdata_r;
   assign reg_we    = reg_we_r;
   assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed-frame bench for spi_reg_bridge: a frame-level model predicts writes,
// aborts and miso bits, and a per-cycle monitor compares the DUT against it.
module tb_spi_reg_bridge;

   logic       clk = 1'b0;
   logic       rstb = 1'b1;
   logic       ena = 1'b1;
   logic       sclk = 1'b0;
   logic       ncs = 1'b1;
   logic       mosi = 1'b0;
   logic [7:0] reg_rdata;
   logic       miso;
   logic [2:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       frame_err;

   int          vectors = 0;
   int          fails = 0;
   logic [7:0]  mem [8];
   logic [7:0]  exp_mem [8];
   logic        pl_en = 1'b0;
   logic [10:0] exp_q [$];
   logic [10:0] mon_e;
   int          err_exp = 0;
   int          err_seen = 0;
   logic        mchk = 1'b0;
   logic        exp_miso = 1'b0;
   logic [15:0] rx;

   always #5 clk = ~clk;

   spi_reg_bridge #(.ADDR_W(3), .DATA_W(8)) dut (
      .clk(clk), .rstb(rstb), .ena(ena), .sclk(sclk), .ncs(ncs), .mosi(mosi),
      .reg_rdata(reg_rdata), .miso(miso), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_we(reg_we), .frame_err(frame_err)
   );

   // Register file seen by the bridge.
   assign reg_rdata = mem[reg_addr];
   always @(posedge clk) begin
      if (pl_en) begin
         for (int i = 0; i < 8; i++) mem[i] <= exp_mem[i];
      end else if (reg_we && ena) begin
         mem[reg_addr] <= reg_wdata;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Per-cycle compare against the frame model.
   always @(negedge clk) begin
      if (rstb && ena) begin
         if (mchk) chk("miso", 32'(miso), 32'(exp_miso));
         if (reg_we) begin
            chk("we_expected", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               chk("we_addr", 32'(reg_addr), 32'(mon_e[10:8]));
               chk("we_data", 32'(reg_wdata), 32'(mon_e[7:0]));
            end
         end
         if (frame_err) begin
            err_seen++;
            chk("err_expected", 32'(err_seen <= err_exp), 32'd1);
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_miso"}, 32'(miso), 32'd0);
      chk({tag, "_addr"}, 32'(reg_addr), 32'd0);
      chk({tag, "_wdata"}, 32'(reg_wdata), 32'd0);
      chk({tag, "_we"}, 32'(reg_we), 32'd0);
      chk({tag, "_err"}, 32'(frame_err), 32'd0);
   endtask

   // One ncs window with ncyc sclk periods; ena_off masks periods, rst_at resets mid-frame.
   task automatic xfer(input logic [7:0] cmd, input logic [7:0] data, input int ncyc,
                       input logic [31:0] ena_off, input int rst_at, output logic [15:0] rxd);
      int          eff;
      logic        abort_f;
      logic [15:0] bits;
      logic [2:0]  a;
      eff  = 0;
      bits = {cmd, data};
      a    = cmd[2:0];
      rxd  = 16'h0000;
      for (int i = 0; i < ncyc; i++) if (!ena_off[i]) eff++;
      abort_f = (eff < 16) && (rst_at < 0);
      if (!abort_f && rst_at < 0 && cmd[7]) begin
         exp_q.push_back({a, data});
         exp_mem[a] = data;
      end
      ncs = 1'b0;
      tick(5);
      for (int i = 0; i < ncyc; i++) begin
         if (i == rst_at) begin
            mchk = 1'b0;
            rstb = 1'b0;
            #1;
            chk_zero("midrst");
            ncs  = 1'b1;
            sclk = 1'b0;
            tick(2);
            rstb = 1'b1;
            tick(5);
            return;
         end
         mosi = (i < 16) ? bits[15-i] : 1'b0;
         tick(1);
         ena = ~ena_off[i];
         tick(4);
         exp_miso = (!cmd[7] && i >= 8) ? exp_mem[a][(i < 16) ? (15 - i) : 0] : 1'b0;
         mchk = 1'b1;
         if (i < 16) rxd[15-i] = miso;
         sclk = 1'b1;
         tick(5);
         mchk = 1'b0;
         sclk = 1'b0;
      end
      tick(1);
      ena = 1'b1;
      tick(4);
      if (abort_f) err_exp++;
      ncs = 1'b1;
      tick(2);
      chk("miso_idle", 32'(miso), 32'd0);
      tick(4);
   endtask

   initial begin
      #3 rstb = 1'b0;
      #1 chk_zero("reset");
      tick(2);
      rstb = 1'b1;
      for (int i = 0; i < 8; i++) exp_mem[i] = 8'(i * 17);
      exp_mem[5] = 8'h3C;
      exp_mem[6] = 8'hFF;
      pl_en = 1'b1;
      tick(1);
      pl_en = 1'b0;
      tick(3);

      xfer(8'h83, 8'hA5, 16, 32'h0, -1, rx);
      chk("t1_addr", 32'(reg_addr), 32'd3);
      chk("t1_mem3", 32'(mem[3]), 32'hA5);
      chk("t1_wdata", 32'(reg_wdata), 32'hA5);

      xfer(8'h05, 8'h00, 16, 32'h0, -1, rx);
      chk("t2_rx", 32'(rx[7:0]), 32'h3C);
      chk("t2_addr", 32'(reg_addr), 32'd5);

      xfer(8'h86, 8'h00, 5, 32'h0, -1, rx);
      chk("t3_err_cnt", 32'(err_seen), 32'd1);
      chk("t3_addr_kept", 32'(reg_addr), 32'd5);
      xfer(8'h81, 8'h11, 16, 32'h0, -1, rx);
      chk("t3_mem1", 32'(mem[1]), 32'h11);

      xfer(8'h84, 8'h5A, 16, 32'h0000_0E00, -1, rx);
      chk("t4_mem4_kept", 32'(mem[4]), 32'h44);
      chk("t4_err_cnt", 32'(err_seen), 32'd2);
      xfer(8'h84, 8'h5A, 16, 32'h0, -1, rx);
      chk("t4_mem4", 32'(mem[4]), 32'h5A);

      xfer(8'h06, 8'h00, 16, 32'h0, 10, rx);
      xfer(8'h87, 8'hC3, 16, 32'h0, -1, rx);
      chk("t5_mem7", 32'(mem[7]), 32'hC3);
      xfer(8'h07, 8'h00, 16, 32'h0, -1, rx);
      chk("t5_rx", 32'(rx[7:0]), 32'hC3);

      xfer(8'h82, 8'h7E, 20, 32'h0, -1, rx);
      chk("t6_mem2", 32'(mem[2]), 32'h7E);
      chk("t6_wdata", 32'(reg_wdata), 32'h7E);

      tick(5);
      chk("we_missing", 32'(exp_q.size()), 32'd0);
      chk("err_total", 32'(err_seen), 32'(err_exp));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
